// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: shared width, opcode and FSM state constants for the ALU share arbiter
package alu_share_arbiter_pkg;
    localparam int WIDTH = 8;
    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_ONES = 3'b111;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/alu_share_arbiter_alu8_core.sv
// alu8_core: combinational 8-bit ALU with carry/borrow out
module alu8_core
    import alu_share_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             cout
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        dif  = {1'b0, a} - {1'b0, b};
        y    = sel == OP_ZERO ? '0 :
               sel == OP_AND  ? a & b :
               sel == OP_OR   ? a | b :
               sel == OP_XOR  ? a ^ b :
               sel == OP_NOT  ? ~a :
               sel == OP_SUB  ? dif[WIDTH-1:0] :
               sel == OP_ADD  ? sum[WIDTH-1:0] : '1;
        // the ninth bit of the subtraction is set exactly when a < b
        cout = sel == OP_SUB ? dif[WIDTH] : sel == OP_ADD ? sum[WIDTH] : 1'b0;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter and sequencer sharing one ALU between two requesters
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       sel0,
    input  logic [2:0]       sel1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             busy
);
    logic [1:0]       state;
    logic             ptr;
    logic             owner;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [2:0]       opsel;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             go;
    logic             win;
    alu8_core u_alu (.a(opa), .b(opb), .sel(opsel), .y(alu_y), .cout(alu_cout));
    always_comb begin
        go   = state == ST_IDLE && !reset && (req0 || req1);
        win  = req1 && (!req0 || ptr);
        gnt0 = go && !win;
        gnt1 = go && win;
        busy = state != ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= 1'b0;
            owner <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            opsel <= OP_ZERO;
            y     <= '0;
            cout  <= 1'b0;
            zero  <= 1'b1;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ST_IDLE: if (go) begin
                    opa   <= win ? a1 : a0;
                    opb   <= win ? b1 : b0;
                    opsel <= win ? sel1 : sel0;
                    owner <= win;
                    ptr   <= !win;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    y     <= alu_y;
                    cout  <= alu_cout;
                    zero  <= alu_y == '0;
                    done0 <= !owner;
                    done1 <= owner;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
